// File: rtl/arcade_input_mapper.sv
// Maps PS/2 key events and per-player joypads onto registered arcade controls.
// Optional autofire gating on the fire buttons is built when INPUT_AUTOFIRE_EN is defined.
module arcade_input_mapper #(
    parameter int PLAYERS     = 2,
    parameter int COIN_CYCLES = 2400000,
    parameter int AF_HALF     = 1200000
) (
    input  logic                  clk_sys,
    input  logic                  RESET,
    input  logic [10:0]           ps2_key,
    input  logic [16*PLAYERS-1:0] joy,
    input  logic                  rotate,
    input  logic [PLAYERS-1:0]    autofire_en,
    output logic [4*PLAYERS-1:0]  dir,
    output logic [PLAYERS-1:0]    fire,
    output logic [PLAYERS-1:0]    start,
    output logic [PLAYERS-1:0]    skip,
    output logic [PLAYERS-1:0]    coin
);
    localparam int CW = (COIN_CYCLES > 1) ? $clog2(COIN_CYCLES) : 1;

    // Control bit order everywhere matches the pad: right, left, down, up, fire, start, coin, skip.
    logic                         armed;
    logic                         tog_q;
    logic                         key_evt;
    logic [7:0]                   key_p1, key_p2;
    logic [7:0]                   hit_p1, hit_p2;
    logic [PLAYERS-1:0][7:0]      raw;
    logic [4*PLAYERS-1:0]         dir_nxt;
    logic [PLAYERS-1:0]           fire_nxt, start_nxt, skip_nxt, coin_raw;
    logic [PLAYERS-1:0]           coin_req_q;
    logic [PLAYERS-1:0][CW-1:0]   coin_cnt;
    logic [PLAYERS-1:0]           af_mask;
    logic [PLAYERS-1:0]           unused_joy_hi;

    // armed stays low for the first clock after reset so a toggle level held
    // through reset, or a held coin request, is absorbed instead of decoded.
    assign key_evt = armed && (ps2_key[10] != tog_q);

    always_comb begin
        hit_p1 = '0;
        hit_p2 = '0;
        case (ps2_key[7:0])
            8'h75:   hit_p1[3] = 1'b1;
            8'h72:   hit_p1[2] = 1'b1;
            8'h6B:   hit_p1[1] = 1'b1;
            8'h74:   hit_p1[0] = 1'b1;
            default: ;
        endcase
        case (ps2_key[8:0])
            9'h029, 9'h014: hit_p1[4] = 1'b1;
            9'h016:  hit_p1[5] = 1'b1;
            9'h02E:  hit_p1[6] = 1'b1;
            9'h003:  hit_p1[7] = 1'b1;
            9'h02D:  hit_p2[3] = 1'b1;
            9'h02B:  hit_p2[2] = 1'b1;
            9'h023:  hit_p2[1] = 1'b1;
            9'h034:  hit_p2[0] = 1'b1;
            9'h01C:  hit_p2[4] = 1'b1;
            9'h01E:  hit_p2[5] = 1'b1;
            9'h036:  hit_p2[6] = 1'b1;
            9'h01B:  hit_p2[7] = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        raw           = '0;
        dir_nxt       = '0;
        fire_nxt      = '0;
        start_nxt     = '0;
        skip_nxt      = '0;
        coin_raw      = '0;
        unused_joy_hi = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            raw[p] = joy[16*p +: 8];
            if (p == 0) raw[p] = raw[p] | key_p1;
            if (p == 1) raw[p] = raw[p] | key_p2;
            unused_joy_hi[p] = ^joy[16*p+8 +: 8];
            // Output nibble is {up, down, left, right}.
            if (rotate)
                dir_nxt[4*p +: 4] = {raw[p][1], raw[p][0], raw[p][2], raw[p][3]};
            else
                dir_nxt[4*p +: 4] = {raw[p][3], raw[p][2], raw[p][1], raw[p][0]};
            fire_nxt[p]  = raw[p][4] & ~af_mask[p];
            start_nxt[p] = raw[p][5];
            coin_raw[p]  = raw[p][6];
            skip_nxt[p]  = raw[p][7];
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            armed      <= 1'b0;
            tog_q      <= 1'b0;
            key_p1     <= '0;
            key_p2     <= '0;
            dir        <= '0;
            fire       <= '0;
            start      <= '0;
            skip       <= '0;
            coin       <= '0;
            coin_req_q <= '0;
            coin_cnt   <= '0;
        end else begin
            armed <= 1'b1;
            tog_q <= ps2_key[10];
            if (key_evt) begin
                key_p1 <= (key_p1 & ~hit_p1) | (hit_p1 & {8{ps2_key[9]}});
                key_p2 <= (key_p2 & ~hit_p2) | (hit_p2 & {8{ps2_key[9]}});
            end
            dir        <= dir_nxt;
            fire       <= fire_nxt;
            start      <= start_nxt;
            skip       <= skip_nxt;
            coin_req_q <= coin_raw;
            // Pulse is timed by a down-counter; new request edges are ignored while it runs.
            for (int p = 0; p < PLAYERS; p++) begin
                if (coin[p]) begin
                    if (coin_cnt[p] == '0)
                        coin[p] <= 1'b0;
                    else
                        coin_cnt[p] <= coin_cnt[p] - CW'(1);
                end else if (armed && coin_raw[p] && !coin_req_q[p]) begin
                    coin[p]     <= 1'b1;
                    coin_cnt[p] <= CW'(COIN_CYCLES - 1);
                end
            end
        end
    end

`ifdef INPUT_AUTOFIRE_EN
    localparam int AW = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;

    logic [AW-1:0] af_cnt;
    logic          af_phase;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            af_cnt   <= '0;
            af_phase <= 1'b1;
        end else if (af_cnt == AW'(AF_HALF - 1)) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt + AW'(1);
        end
    end

    assign af_mask = autofire_en & {PLAYERS{~af_phase}};
`else
    logic unused_autofire;
    assign unused_autofire = ^autofire_en;
    assign af_mask         = '0;
`endif

endmodule
